trace_match_logger: RTL and testbench
=====================================

// Module: trace_match_logger
// PURPOSE
//  Downstream of the trace pattern matcher. Takes per-rule one-cycle match strobes and drives
//  the board trigger output (trig_out), in pulse or toggle mode. Logs each match as a 64-bit
//  {rule[7:0], cycle[55:0]} record in a FWFT FIFO, which the USB register block drains
//  through REG_SNIFF_FIFO_RD. All logic runs in the trace clock domain.
// PARAMETERS
//  pNUM_PATTERNS  8   number of match rules / width of I_match
//  pCYCLE_WIDTH   56  timestamp counter width; rule field is 64-pCYCLE_WIDTH = 8 bits
//  pFIFO_DEPTH    16  log FIFO entries; power of two, >= 2
// PORTS
//  trace_clk        in   1      trace clock (pll_clk1)
//  resetn           in   1      asynchronous active-low reset
//  I_arm            in   1      level; REG_ARM, already synchronised to trace_clk
//  I_pattern_enable in   pNUM_PATTERNS  REG_PATTERN_ENABLE mask
//  I_trig_toggle    in   1      REG_TRIG_TOGGLE: 0 = pulse, 1 = toggle
//  I_trig_enable    in   1      REG_TRACE_TRIG_ENABLE
//  I_match          in   pNUM_PATTERNS  one-cycle match strobes from matcher
//  I_fifo_rd        in   1      pop strobe, one trace_clk cycle per word
//  O_trig_out       out  1      trigger to 20-pin connector
//  O_fifo_dout      out  64     head record; valid while !O_fifo_empty
//  O_fifo_empty     out  1      FIFO empty
//  O_fifo_full      out  1      FIFO full
//  O_overflow       out  1      sticky: a match was lost because the FIFO was full
//  O_collision      out  1      sticky: >1 enabled rule matched in the same cycle
// BEHAVIOUR
//  Reset: cycle=0, state IDLE, FIFO empty. All outputs 0 except O_fifo_empty=1.
//  cycle: free-running from reset release, +1 every trace_clk; wraps 2^56-1 -> 0.
//  hit = I_match & I_pattern_enable; rule = lowest set index of hit.
//  FSM (state register is internal):
//   IDLE  -> ARMED on I_arm=1. Matches are ignored in IDLE.
//   ARMED -> IDLE on I_arm=0. On |hit: trigger fires and a record is written.
//   ARMED -> OVFL on |hit while full and no same-cycle pop; set O_overflow; no write.
//   OVFL  : trigger still fires; logging stops. -> IDLE on I_arm=0.
//  O_overflow and O_collision clear on the IDLE->ARMED transition.
//  Trigger: registered, 1-cycle latency from I_match. Only in ARMED/OVFL with I_trig_enable=1.
//   Pulse mode: high for exactly one cycle per hit cycle.
//   Toggle mode: inverts once per hit cycle.
//   I_trig_enable=0 forces the output to 0 and resets the toggle state.
//  Record: {rule, cycle value sampled in the I_match cycle}. Written on the same edge;
//   O_fifo_empty falls in the next cycle.
//  Collision: if popcount(hit) > 1, log only the lowest rule, set O_collision, one trigger event.
//  FIFO: first-word-fall-through. I_fifo_rd while empty is ignored (no underflow).
//   Simultaneous pop and write while full: both accepted, occupancy unchanged.
//  I_arm dropping does not flush the FIFO. Async reset mid-operation clears everything,
//   including FIFO contents.
// CONFIGURATION
//  TRACE_LOGGER_STATS_EN defined: adds O_match_count [31:0] and O_drop_count [31:0].
//   Both are saturating counts of records logged and matches lost (overflow + collision
//   losers). Both clear on IDLE->ARMED.
//  Not defined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  trace_logger_pkg: FSM state enum, RECORD_W=64, RULE_W, priority-encode function.
//  Sub-module trace_logger_fifo: synchronous FWFT FIFO (width, depth parameters),
//   with full/empty flags and async active-low reset.
// TESTING
//  1 Arm, enable 8'hff, pulse mode; I_match=8'h04 at cycle 100 -> O_trig_out high for one
//    cycle at 101; record 64'h02_00000000000064.
//  2 Toggle mode; hits at cycles 10 and 20 -> O_trig_out rises at 11, falls at 21.
//    Clearing I_trig_enable forces 0.
//  3 I_match=8'h06 in one cycle -> one record with rule 1, O_collision=1, one trigger pulse.
//  4 Fill 16 records with no reads; 17th hit -> O_overflow=1, state OVFL, trigger still
//    pulses; pop all 16 in order, then O_fifo_empty=1. Extra pop is ignored.
//  5 Pattern enable 8'hfe, I_match=8'h01 -> no trigger and no record. Disarmed, I_match=8'hff
//    -> nothing.
//  6 Force cycle to 2^56-2 (bench force); hits at the next two cycles -> timestamps
//    FF..FF then 0. Assert resetn low mid-stream -> FIFO empty, outputs 0.

Source files
------------

// File: rtl/trace_logger_pkg.sv
// Shared constants, FSM state encoding and helper functions for the trace match logger.
// Record layout is {rule, cycle}, RECORD_W bits in total.
package trace_logger_pkg;
    localparam int RECORD_W  = 64;
    localparam int CYCLE_W   = 56;
    localparam int RULE_W    = RECORD_W - CYCLE_W;
    localparam int MAX_RULES = 1 << RULE_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_OVFL  = 2'd2;

    // Index of the lowest set bit; the lowest-numbered rule wins a collision.
    function automatic logic [RULE_W-1:0] lowest_rule(input logic [MAX_RULES-1:0] hit);
        lowest_rule = '0;
        for (int i = MAX_RULES - 1; i >= 0; i--) begin
            if (hit[i]) lowest_rule = RULE_W'(i);
        end
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction
endpackage

// File: rtl/trace_match_logger_if.sv
// Log FIFO read port between the logger (slave) and the register block that drains it (master).
// Head record is valid whenever O_fifo_empty is low; I_fifo_rd pops one word per cycle.
interface trace_match_logger_if;
    import trace_logger_pkg::*;

    logic                I_fifo_rd;
    logic [RECORD_W-1:0] O_fifo_dout;
    logic                O_fifo_empty;
    logic                O_fifo_full;

    modport master (output I_fifo_rd, input O_fifo_dout, O_fifo_empty, O_fifo_full);
    modport slave  (input I_fifo_rd, output O_fifo_dout, O_fifo_empty, O_fifo_full);
endinterface

// File: rtl/trace_logger_fifo.sv
// First-word-fall-through FIFO: write visible at the head one cycle later, head combinational.
// Backpressure: writes while full are dropped unless a pop happens in the same cycle; pops while empty are ignored.
module trace_logger_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             trace_clk,
    input  logic             resetn,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_rd    = rd_i && !empty_o;
    assign do_wr    = wr_i && (!full_o || do_rd);
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};

    always_ff @(posedge trace_clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/trace_match_logger.sv
// Match strobes -> registered trigger (1-cycle latency) and {rule, cycle} log records; TRACE_LOGGER_STATS_EN adds counters.
// No backpressure on matches: a hit that finds the log full is dropped, flagged and logging stops until re-armed.
module trace_match_logger
    import trace_logger_pkg::*;
#(
    parameter int pNUM_PATTERNS = 8,
    parameter int pCYCLE_WIDTH  = 56,
    parameter int pFIFO_DEPTH   = 16
) (
    input  logic                     trace_clk,
    input  logic                     resetn,
    input  logic                     I_arm,
    input  logic [pNUM_PATTERNS-1:0] I_pattern_enable,
    input  logic                     I_trig_toggle,
    input  logic                     I_trig_enable,
    input  logic [pNUM_PATTERNS-1:0] I_match,
    trace_match_logger_if.slave      fifo_if,
    output logic                     O_trig_out,
    output logic                     O_overflow,
    output logic                     O_collision
`ifdef TRACE_LOGGER_STATS_EN
    ,
    output logic [31:0]              O_match_count,
    output logic [31:0]              O_drop_count
`endif
);
    localparam int RW = RECORD_W - pCYCLE_WIDTH;

    logic [1:0]               state_q, state_d;
    logic [pCYCLE_WIDTH-1:0]  cycle_q, cycle_d;
    logic                     trig_q, trig_d, tog_q, tog_d;
    logic                     ovf_q, ovf_d, col_q, col_d;
    logic [pNUM_PATTERNS-1:0] hit;
    logic                     active, any_hit, multi_hit, arm_rise, lost, wr, trig_evt;
    logic [RECORD_W-1:0]      wr_rec;

    assign cycle_d   = cycle_q + pCYCLE_WIDTH'(1);
    assign hit       = I_match & I_pattern_enable;
    assign any_hit   = |hit;
    assign multi_hit = |(hit & (hit - pNUM_PATTERNS'(1)));
    assign active    = (state_q == ST_ARMED) || (state_q == ST_OVFL);
    assign arm_rise  = (state_q == ST_IDLE) && I_arm;
    // A same-cycle pop frees the slot, so a hit while full is still logged.
    assign wr        = (state_q == ST_ARMED) && any_hit && (!fifo_if.O_fifo_full || fifo_if.I_fifo_rd);
    assign lost      = (state_q == ST_ARMED) && any_hit && fifo_if.O_fifo_full && !fifo_if.I_fifo_rd;
    assign trig_evt  = active && any_hit && I_trig_enable;
    assign wr_rec    = {RW'(lowest_rule(MAX_RULES'(hit))), cycle_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (I_arm) state_d = ST_ARMED;
            ST_ARMED: if (!I_arm) state_d = ST_IDLE;
                      else if (lost) state_d = ST_OVFL;
            ST_OVFL:  if (!I_arm) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign ovf_d  = arm_rise ? 1'b0 : (ovf_q | lost);
    assign col_d  = arm_rise ? 1'b0 : (col_q | (active && multi_hit));
    assign tog_d  = !I_trig_enable ? 1'b0 : (I_trig_toggle ? (tog_q ^ trig_evt) : tog_q);
    assign trig_d = I_trig_toggle ? tog_d : trig_evt;

    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cycle_q <= '0;
            trig_q  <= 1'b0;
            tog_q   <= 1'b0;
            ovf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            trig_q  <= trig_d;
            tog_q   <= tog_d;
            ovf_q   <= ovf_d;
            col_q   <= col_d;
        end
    end

    assign O_trig_out  = trig_q;
    assign O_overflow  = ovf_q;
    assign O_collision = col_q;

    trace_logger_fifo #(
        .WIDTH (RECORD_W),
        .DEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .trace_clk (trace_clk),
        .resetn    (resetn),
        .wr_i      (wr),
        .wr_dat_i  (wr_rec),
        .rd_i      (fifo_if.I_fifo_rd),
        .rd_dat_o  (fifo_if.O_fifo_dout),
        .empty_o   (fifo_if.O_fifo_empty),
        .full_o    (fifo_if.O_fifo_full)
    );

`ifdef TRACE_LOGGER_STATS_EN
    logic [31:0] match_cnt_q, drop_cnt_q, drop_inc;

    // Every enabled hit that is not the one logged record counts as dropped.
    assign drop_inc = (active && any_hit) ? (32'($countones(hit)) - {31'd0, wr}) : 32'd0;

    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (arm_rise) begin
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            match_cnt_q <= sat_add(match_cnt_q, {31'd0, wr});
            drop_cnt_q  <= sat_add(drop_cnt_q, drop_inc);
        end
    end

    assign O_match_count = match_cnt_q;
    assign O_drop_count  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_trace_match_logger.sv
// Bench for trace_match_logger: vector table, directed corner sequences and randomized traffic vs a queue model.
module tb_trace_match_logger;
    localparam int   DEPTH = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       trace_clk = 1'b0;
    logic       resetn = 1'b0;
    logic       arm, tog, ten, trig, ovf, col;
    logic [7:0] pen, match;
`ifdef TRACE_LOGGER_STATS_EN
    logic [31:0] mcnt, dcnt;
`endif

    trace_match_logger_if fif ();

    trace_match_logger dut (
        .trace_clk        (trace_clk),
        .resetn           (resetn),
        .I_arm            (arm),
        .I_pattern_enable (pen),
        .I_trig_toggle    (tog),
        .I_trig_enable    (ten),
        .I_match          (match),
        .fifo_if          (fif),
        .O_trig_out       (trig),
        .O_overflow       (ovf),
        .O_collision      (col)
`ifdef TRACE_LOGGER_STATS_EN
        ,
        .O_match_count    (mcnt),
        .O_drop_count     (dcnt)
`endif
    );

    always #5 trace_clk = ~trace_clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state
    logic [63:0] mq[$];
    logic        m_armed, m_ovfl, e_ovf, e_col, e_tog, e_trig;
    logic [55:0] m_cyc;

    typedef struct {
        logic        arm;
        logic [7:0]  pen;
        logic        tog;
        logic        ten;
        logic [7:0]  match;
        logic        rd;
        logic        e_trig;
        logic        e_empty;
        logic        e_col;
        logic [63:0] e_dout;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int lowest(input logic [7:0] h);
        for (int i = 0; i < 8; i++) if (h[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_armed = 0; m_ovfl = 0; e_ovf = 0; e_col = 0; e_tog = 0; e_trig = 0;
        m_cyc = '0;
    endtask

    // Expected state after the coming clock edge, from the current inputs.
    task automatic model_step();
        logic [7:0] hit;
        logic       logged, evt;
        hit = match & pen;
        logged = 0;
        evt = 0;
        if (m_armed && hit != 0) begin
            if ($countones(hit) > 1) e_col = 1;
            evt = ten;
            if (!m_ovfl) begin
                if (mq.size() == DEPTH && !fif.I_fifo_rd) begin
                    m_ovfl = 1;
                    e_ovf = 1;
                end else logged = 1;
            end
        end
        if (fif.I_fifo_rd && mq.size() != 0) void'(mq.pop_front());
        if (logged) mq.push_back({8'(lowest(hit)), m_cyc});
        if (!ten) begin
            e_tog = 0;
            e_trig = 0;
        end else if (tog) begin
            if (evt) e_tog = !e_tog;
            e_trig = e_tog;
        end else e_trig = evt;
        if (!m_armed && arm) begin
            m_armed = 1; e_ovf = 0; e_col = 0;
        end else if (m_armed && !arm) begin
            m_armed = 0; m_ovfl = 0;
        end
        m_cyc = m_cyc + 56'd1;
    endtask

    task automatic step();
        model_step();
        @(posedge trace_clk);
        @(negedge trace_clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".trig"}, 64'(trig), 64'(e_trig));
        chk({tag, ".empty"}, 64'(fif.O_fifo_empty), 64'(mq.size() == 0));
        chk({tag, ".full"}, 64'(fif.O_fifo_full), 64'(mq.size() == DEPTH));
        chk({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
        chk({tag, ".col"}, 64'(col), 64'(e_col));
        if (mq.size() != 0) chk({tag, ".dout"}, fif.O_fifo_dout, mq[0]);
    endtask

    task automatic do_reset();
        resetn = 0;
        arm = 0; pen = 0; tog = 0; ten = 0; match = 0; fif.I_fifo_rd = 0;
        model_reset();
        @(negedge trace_clk);
        @(negedge trace_clk);
        resetn = 1;
    endtask

    task automatic add(input logic a, input logic [7:0] p, input logic tg, input logic te,
                       input logic [7:0] m, input logic r, input logic et, input logic ee,
                       input logic ec, input logic [63:0] ed);
        vec_t v;
        v = '{a, p, tg, te, m, r, et, ee, ec, ed};
        tbl.push_back(v);
    endtask

    initial begin
        int rd_rate;
        // Row index equals the cycle value sampled in that row (fresh reset).
        add(H, 8'hff, L, H, 8'h00, L,  L, H, L, 64'h0);
        add(H, 8'hff, L, H, 8'h06, L,  H, L, H, {8'h01, 56'd1});
        add(H, 8'hff, L, H, 8'h00, L,  L, L, H, {8'h01, 56'd1});
        add(H, 8'hff, L, H, 8'h00, H,  L, H, H, 64'h0);
        add(H, 8'hfe, L, H, 8'h01, L,  L, H, H, 64'h0);
        add(L, 8'hfe, L, H, 8'h00, L,  L, H, H, 64'h0);
        add(L, 8'hff, L, H, 8'hff, L,  L, H, H, 64'h0);
        add(H, 8'hff, L, H, 8'h00, L,  L, H, L, 64'h0);
        add(H, 8'hff, H, H, 8'h00, L,  L, H, L, 64'h0);
        add(H, 8'hff, H, H, 8'h10, L,  H, L, L, {8'h04, 56'd9});
        add(H, 8'hff, H, H, 8'h00, L,  H, L, L, {8'h04, 56'd9});
        add(H, 8'hff, H, H, 8'h80, H,  L, L, L, {8'h07, 56'd11});
        add(H, 8'hff, H, H, 8'h01, L,  H, L, L, {8'h07, 56'd11});
        add(H, 8'hff, H, L, 8'h00, L,  L, L, L, {8'h07, 56'd11});
        add(H, 8'hff, H, H, 8'h02, L,  H, L, L, {8'h07, 56'd11});
        add(H, 8'hff, L, H, 8'h00, L,  L, L, L, {8'h07, 56'd11});
        add(H, 8'hff, L, H, 8'h00, H,  L, L, L, {8'h00, 56'd12});
        add(H, 8'hff, L, H, 8'h00, H,  L, L, L, {8'h01, 56'd14});
        add(H, 8'hff, L, H, 8'h00, H,  L, H, L, 64'h0);
        add(H, 8'hff, L, H, 8'h00, H,  L, H, L, 64'h0);

        // Reset state
        do_reset();
        chk("rst.trig", 64'(trig), 64'd0);
        chk("rst.empty", 64'(fif.O_fifo_empty), 64'd1);
        chk("rst.full", 64'(fif.O_fifo_full), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        chk("rst.col", 64'(col), 64'd0);

        // Vector table
        foreach (tbl[i]) begin
            arm = tbl[i].arm; pen = tbl[i].pen; tog = tbl[i].tog; ten = tbl[i].ten;
            match = tbl[i].match; fif.I_fifo_rd = tbl[i].rd;
            step();
            chk($sformatf("vec%0d.trig", i), 64'(trig), 64'(tbl[i].e_trig));
            chk($sformatf("vec%0d.empty", i), 64'(fif.O_fifo_empty), 64'(tbl[i].e_empty));
            chk($sformatf("vec%0d.col", i), 64'(col), 64'(tbl[i].e_col));
            if (!tbl[i].e_empty) chk($sformatf("vec%0d.dout", i), fif.O_fifo_dout, tbl[i].e_dout);
        end

        // Single pulse and record at cycle 100
        do_reset();
        arm = 1; pen = 8'hff; ten = 1; tog = 0;
        for (int k = 0; k < 200 && m_cyc != 56'd100; k++) step();
        match = 8'h04;
        step();
        chk("c100.trig_hi", 64'(trig), 64'd1);
        chk("c100.empty", 64'(fif.O_fifo_empty), 64'd0);
        chk("c100.record", fif.O_fifo_dout, 64'h0200_0000_0000_0064);
        match = 8'h00;
        step();
        chk("c100.trig_lo", 64'(trig), 64'd0);
        check_all("c100");

        // Fill, full-with-pop, overflow, trigger in OVFL, drain with extra pop
        do_reset();
        arm = 1; pen = 8'hff; ten = 1; tog = 0;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            match = 8'(1 << (i % 8));
            step();
            check_all("fill");
        end
        chk("fill.full", 64'(fif.O_fifo_full), 64'd1);
        match = 8'h20; fif.I_fifo_rd = 1;
        step();
        check_all("fullpop");
        match = 8'h40; fif.I_fifo_rd = 0;
        step();
        check_all("ovfl");
        chk("ovfl.flag", 64'(ovf), 64'd1);
        match = 8'h08; fif.I_fifo_rd = 1;
        step();
        check_all("ovfl_trig");
        match = 8'h00;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step();
            check_all("drain");
        end
        chk("drain.empty", 64'(fif.O_fifo_empty), 64'd1);
        fif.I_fifo_rd = 0;

        // Timestamp wrap, then async reset with records pending
        do_reset();
        arm = 1; pen = 8'hff; ten = 1; tog = 0;
        step();
        force dut.cycle_d = 56'hFF_FFFF_FFFF_FFFE;
        step();
        release dut.cycle_d;
        m_cyc = 56'hFF_FFFF_FFFF_FFFE;
        step();
        match = 8'h01;
        step();
        check_all("wrap_ff");
        chk("wrap_ff.record", fif.O_fifo_dout, {8'h00, 56'hFF_FFFF_FFFF_FFFF});
        match = 8'h02;
        step();
        check_all("wrap_0");
        match = 8'h00; fif.I_fifo_rd = 1;
        step();
        chk("wrap_0.record", fif.O_fifo_dout, {8'h01, 56'h0});
        match = 8'h06; fif.I_fifo_rd = 0;
        step();
        resetn = 0;
        #1;
        chk("arst.empty", 64'(fif.O_fifo_empty), 64'd1);
        chk("arst.trig", 64'(trig), 64'd0);
        chk("arst.col", 64'(col), 64'd0);
        chk("arst.full", 64'(fif.O_fifo_full), 64'd0);

        // Randomized traffic against the model
        do_reset();
        rd_rate = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) rd_rate = $urandom_range(5, 95);
            arm   = ($urandom_range(0, 63) != 0);
            pen   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff;
            match = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
            fif.I_fifo_rd = ($urandom_range(0, 99) < rd_rate);
            if ($urandom_range(0, 49) == 0) tog = ~tog;
            ten   = ($urandom_range(0, 9) != 0);
            step();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
